// File: rtl/serial_subtractor_ctrl_if.sv
// Handshake and operand/result bundle for serial_subtractor_ctrl.
// master drives the request and operands; slave returns status and result.
interface serial_subtractor_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borr;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Borr
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Borr
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A-B: one borrow-in subtract cell walked LSB-first over WIDTH cycles.
// Optional macro SERIAL_SUB_SAT_EN clamps Diff to 0 when the final borrow is set.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_subtractor_ctrl_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_sh_q;
  logic [WIDTH-1:0]  b_sh_q;
  logic [WIDTH-1:0]  res_sh_q;
  logic [WIDTH-1:0]  diff_q;
  logic [CntW-1:0]   cnt_q;
  logic              br_q;
  logic              borr_q;
  logic              busy_q;
  logic              done_q;

  logic              a0;
  logic              b0;
  logic              d;
  logic              br_next;
  logic              last;
  logic [WIDTH-1:0]  res_next;

  always_comb begin
    a0       = a_sh_q[0];
    b0       = b_sh_q[0];
    d        = a0 ^ b0 ^ br_q;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    res_next = {d, res_sh_q[WIDTH-1:1]};
    last     = (cnt_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_sh_q   <= bus.A;
            b_sh_q   <= bus.B;
            res_sh_q <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_next;
          br_q     <= br_next;
          if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            borr_q  <= br_next;
`ifdef SERIAL_SUB_SAT_EN
            diff_q  <= br_next ? '0 : res_next;
`else
            diff_q  <= res_next;
`endif
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // back-to-back: reload straight from the completion cycle
            a_sh_q   <= bus.A;
            b_sh_q   <= bus.B;
            res_sh_q <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Diff = diff_q;
  assign bus.Borr = borr_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Randomized self-checking bench for serial_subtractor_ctrl against an arithmetic model.
module tb_serial_subtractor_ctrl;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular subtraction, borrow is unsigned compare.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] dv;
    logic         bv;
    dv = a - b;
    bv = (a < b);
`ifdef SERIAL_SUB_SAT_EN
    if (bv) dv = '0;
`endif
    return {bv, dv};
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered at the negedge just after the accepting edge; leaves at the done negedge.
  task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit mid_start);
    int         cyc;
    int         busy_cnt;
    logic [W:0] exp;
    cyc = 0;
    busy_cnt = 0;
    exp = ref_sub(a, b);
    while (!bus.done && cyc < 64) begin
      if (bus.busy) busy_cnt++;
      if (mid_start && cyc == 3) begin
        bus.A = W'($urandom);
        bus.B = W'($urandom);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(W));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
    check({tag, "_diff"}, 64'(bus.Diff), 64'(exp[W-1:0]));
    check({tag, "_borr"}, 64'(bus.Borr), 64'(exp[W]));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit mid_start);
    logic [W:0] exp;
    exp = ref_sub(a, b);
    start_op(a, b);
    wait_result(tag, a, b, mid_start);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
    check({tag, "_diff_hold"}, 64'(bus.Diff), 64'(exp[W-1:0]));
  endtask

  initial begin
    int seen_done;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_diff", 64'(bus.Diff), 64'(0));
    check("rst_borr", 64'(bus.Borr), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("basic", 8'd200, 8'd55, 1'b0);
    check("basic_const", 64'(bus.Diff), 64'(145));
    run_op("under", 8'd5, 8'd9, 1'b0);
`ifdef SERIAL_SUB_SAT_EN
    check("under_const", 64'(bus.Diff), 64'(0));
`else
    check("under_const", 64'(bus.Diff), 64'(252));
`endif
    run_op("equal", 8'hA5, 8'hA5, 1'b0);
    run_op("zero_ff", 8'h00, 8'hFF, 1'b0);
    run_op("mid_start", 8'd100, 8'd37, 1'b1);

    // Back-to-back: start held through the done cycle.
    start_op(8'd50, 8'd60);
    wait_result("b2b_first", 8'd50, 8'd60, 1'b0);
    start_op(8'd10, 8'd3);
    check("b2b_done_single", 64'(bus.done), 64'(0));
    check("b2b_busy", 64'(bus.busy), 64'(1));
    wait_result("b2b_second", 8'd10, 8'd3, 1'b0);
    check("b2b_const", 64'(bus.Diff), 64'(7));
    @(negedge clk);

    // Reset in the middle of RUN.
    start_op(8'd77, 8'd11);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_done", 64'(bus.done), 64'(0));
    check("mid_rst_diff", 64'(bus.Diff), 64'(0));
    check("mid_rst_borr", 64'(bus.Borr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    check("mid_rst_no_done", 64'(seen_done), 64'(0));
    run_op("after_rst", 8'd33, 8'd34, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op("rand", W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
